// File: rtl/adaboost_pkg.sv
// adaboost_pkg: shared widths, depth and one-hot state encodings for the weight loader
package adaboost_pkg;
    localparam int WW    = 9;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LOAD   = 4'b0010,
        LOADED = 4'b0100,
        SCAN   = 4'b1000
    } state_t;
endpackage

// File: rtl/adaboost_lane_demux.sv
// adaboost_lane_demux: routes one accepted beat to the selected lane, other lanes keep their registered values
module adaboost_lane_demux #(
    parameter int WW = adaboost_pkg::WW,
    parameter int AW = adaboost_pkg::AW
) (
    input  logic                  en,
    input  logic [1:0]            lane,
    input  logic [AW-1:0]         idx,
    input  logic [WW-1:0]         weight,
    input  logic [2:0][AW-1:0]    addr_q,
    input  logic [2:0][WW-1:0]    weight_q,
    output logic [2:0]            write,
    output logic [2:0][AW-1:0]    addr_d,
    output logic [2:0][WW-1:0]    weight_d
);
    genvar i;
    for (i = 0; i < 3; i++) begin : g_lane
        assign write[i]    = en && lane == 2'(i);
        assign addr_d[i]   = write[i] ? idx : addr_q[i];
        assign weight_d[i] = write[i] ? weight : weight_q[i];
    end
endmodule

// File: rtl/adaboost_weight_loader.sv
// adaboost_weight_loader: fills three learner weight memories from one stream and drives read sweeps
module adaboost_weight_loader #(
    parameter int WW    = adaboost_pkg::WW,
    parameter int AW    = adaboost_pkg::AW,
    parameter int DEPTH = adaboost_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          scan_start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WW-1:0] in_weight,
    input  logic          in_last,
    output logic          write1,
    output logic          write2,
    output logic          write3,
    output logic          read1,
    output logic          read2,
    output logic          read3,
    output logic [AW-1:0] address1,
    output logic [AW-1:0] address2,
    output logic [AW-1:0] address3,
    output logic [WW-1:0] weight1,
    output logic [WW-1:0] weight2,
    output logic [WW-1:0] weight3,
    output logic          en,
    output logic          load_done,
    output logic          scan_done,
    output logic          err
);
    import adaboost_pkg::*;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t               state, state_n;
    logic [1:0]           lane, lane_n;
    logic [AW-1:0]        idx, idx_n;
    logic [2:0]           wr, wr_n, dm_wr;
    logic [2:0][AW-1:0]   addr, addr_n, dm_addr;
    logic [2:0][WW-1:0]   wt, wt_n, dm_wt;
    logic                 rd, rd_n, done_n, sdone_n, err_n;
    logic                 acc, last_beat, idx_end;

    assign in_ready  = state == LOAD;
    assign acc       = in_valid && in_ready && !load_start;
    assign idx_end   = idx == LAST;
    assign last_beat = lane == 2'd2 && idx_end;

    assign write1   = wr[0];
    assign write2   = wr[1];
    assign write3   = wr[2];
    assign address1 = addr[0];
    assign address2 = addr[1];
    assign address3 = addr[2];
    assign weight1  = wt[0];
    assign weight2  = wt[1];
    assign weight3  = wt[2];
    assign read1    = rd;
    assign read2    = rd;
    assign read3    = rd;
    assign en       = rd;

    adaboost_lane_demux #(.WW(WW), .AW(AW)) u_demux (
        .en       (acc),
        .lane     (lane),
        .idx      (idx),
        .weight   (in_weight),
        .addr_q   (addr),
        .weight_q (wt),
        .write    (dm_wr),
        .addr_d   (dm_addr),
        .weight_d (dm_wt)
    );

    // next state, counters and next registered outputs; strobes default low every cycle
    always_comb begin
        state_n = state;
        lane_n  = lane;
        idx_n   = idx;
        wr_n    = '0;
        addr_n  = addr;
        wt_n    = wt;
        rd_n    = 1'b0;
        done_n  = load_done;
        sdone_n = 1'b0;
        err_n   = err;
        case (state)
            IDLE, LOADED: begin
                if (load_start) begin
                    state_n = LOAD;
                    lane_n  = '0;
                    idx_n   = '0;
                    err_n   = 1'b0;
                    done_n  = 1'b0;
                end else if (state == LOADED && scan_start) begin
                    state_n = SCAN;
                    rd_n    = 1'b1;
                    addr_n  = '0;
                    idx_n   = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    lane_n = '0;
                    idx_n  = '0;
                    err_n  = 1'b0;
                end else if (acc) begin
                    wr_n   = dm_wr;
                    addr_n = dm_addr;
                    wt_n   = dm_wt;
                    err_n  = err | (in_last != last_beat);
                    idx_n  = idx_end ? '0 : idx + 1'b1;
                    lane_n = idx_end ? lane + 2'd1 : lane;
                    if (last_beat) begin
                        state_n = LOADED;
                        done_n  = 1'b1;
                        lane_n  = '0;
                    end
                end
            end
            SCAN: begin
                rd_n    = !idx_end;
                sdone_n = idx_end;
                idx_n   = idx_end ? '0 : idx + 1'b1;
                addr_n  = idx_end ? addr : {3{idx + 1'b1}};
                if (idx_end) state_n = LOADED;
            end
            default: begin
                state_n = IDLE;
                done_n  = 1'b0;
            end
        endcase
    end

    // state and output registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lane      <= '0;
            idx       <= '0;
            wr        <= '0;
            addr      <= '0;
            wt        <= '0;
            rd        <= 1'b0;
            load_done <= 1'b0;
            scan_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            lane      <= lane_n;
            idx       <= idx_n;
            wr        <= wr_n;
            addr      <= addr_n;
            wt        <= wt_n;
            rd        <= rd_n;
            load_done <= done_n;
            scan_done <= sdone_n;
            err       <= err_n;
        end
    end
endmodule

// File: tb/tb_adaboost_weight_loader.sv
// tb_adaboost_weight_loader: directed table-driven loads plus hand-written scan, collision and reset sequences
module tb_adaboost_weight_loader;
    logic       clk = 0, rst = 0;
    logic       load_start = 0, scan_start = 0, in_valid = 0, in_last = 0;
    logic [8:0] in_weight = '0;
    logic       in_ready, write1, write2, write3, read1, read2, read3, en;
    logic       load_done, scan_done, err;
    logic [4:0] address1, address2, address3;
    logic [8:0] weight1, weight2, weight3;

    adaboost_weight_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .scan_start(scan_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight), .in_last(in_last),
        .write1(write1), .write2(write2), .write3(write3),
        .read1(read1), .read2(read2), .read3(read3),
        .address1(address1), .address2(address2), .address3(address3),
        .weight1(weight1), .weight2(weight2), .weight3(weight3),
        .en(en), .load_done(load_done), .scan_done(scan_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int base;
        bit tog;
        int last_at;
        int cyc;
        int exp_err;
    } vec_t;

    int errors = 0, checks = 0;
    logic [8:0] m1 [32], m2 [32], m3 [32];
    int wcnt = 0, multi = 0, sbad = 0;
    bit pend = 0;

    // memory image model plus strobe-only-after-accept tracking
    always @(negedge clk) begin
        if (!rst) pend = 0;
        else begin
            if (write1) m1[address1] = weight1;
            if (write2) m2[address2] = weight2;
            if (write3) m3[address3] = weight3;
            wcnt += int'(write1) + int'(write2) + int'(write3);
            if (int'(write1) + int'(write2) + int'(write3) > 1) multi++;
            if ((write1 | write2 | write3) != pend) sbad++;
            pend = in_valid && in_ready;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_run(input int base, input bit tog, input int last_at, input int exp_cyc, input int exp_err);
        int beat = 0, cycles = 0, w0, m0, s0, bad;
        bit acc;
        w0 = wcnt; m0 = multi; s0 = sbad;
        @(posedge clk); #1;
        load_start = 1;
        @(posedge clk); #1;
        load_start = 0;
        chk("err_cleared_on_start", err, 0);
        chk("load_done_low_in_load", load_done, 0);
        chk("in_ready_in_load", in_ready, 1);
        while (beat < 96 && cycles < 400) begin
            in_valid  = !tog || cycles % 2 == 0;
            in_weight = 9'(base + beat);
            in_last   = beat == last_at;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) beat++;
            cycles++;
        end
        in_valid = 0;
        in_last  = 0;
        chk("load_cycles", cycles, exp_cyc);
        chk("load_done_with_final_write", load_done, 1);
        chk("final_write3", write3, 1);
        chk("final_address3", address3, 31);
        chk("err", err, exp_err);
        chk("in_ready_after_load", in_ready, 0);
        @(negedge clk);
        #1;
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            if (m1[a] != 9'(base + a)) bad++;
            if (m2[a] != 9'(base + 32 + a)) bad++;
            if (m3[a] != 9'(base + 64 + a)) bad++;
        end
        chk("image_bad_words", bad, 0);
        chk("write_strobes", wcnt - w0, 96);
        chk("multi_lane_strobes", multi - m0, 0);
        chk("strobe_without_beat", sbad - s0, 0);
    endtask

    task automatic sweep(input bit inject);
        int bad = 0;
        @(posedge clk); #1;
        scan_start = 1;
        @(posedge clk); #1;
        scan_start = 0;
        for (int k = 0; k < 32; k++) begin
            scan_start = inject && (k == 5 || k == 31);
            load_start = inject && k == 5;
            if (!(read1 && read2 && read3 && en) || address1 != 5'(k) || address2 != 5'(k) ||
                address3 != 5'(k) || (write1 | write2 | write3) || scan_done || in_ready) bad++;
            @(posedge clk); #1;
        end
        scan_start = 0;
        load_start = 0;
        chk("sweep_bad_cycles", bad, 0);
        chk("scan_done_pulse", scan_done, 1);
        chk("read_dropped", int'(read1 | read2 | read3), 0);
        chk("en_dropped", en, 0);
        chk("load_done_kept", load_done, 1);
        @(posedge clk); #1;
        chk("scan_done_one_cycle", scan_done, 0);
        chk("no_load_after_sweep", in_ready, 0);
    endtask

    function automatic int outs_or();
        return int'(|{in_ready, write1, write2, write3, read1, read2, read3, address1, address2,
                      address3, weight1, weight2, weight3, en, load_done, scan_done, err});
    endfunction

    vec_t tab [4];

    initial begin
        tab[0] = '{base: 0,   tog: 0, last_at: 95, cyc: 96,  exp_err: 0};
        tab[1] = '{base: 0,   tog: 1, last_at: 95, cyc: 191, exp_err: 0};
        tab[2] = '{base: 0,   tog: 0, last_at: 10, cyc: 96,  exp_err: 1};
        tab[3] = '{base: 100, tog: 0, last_at: 95, cyc: 96,  exp_err: 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", outs_or(), 0);
        rst = 1;
        @(posedge clk); #1;
        chk("idle_no_ready", in_ready, 0);
        scan_start = 1;
        @(posedge clk); #1;
        scan_start = 0;
        chk("idle_ignores_scan", read1, 0);

        for (int v = 0; v < 4; v++)
            load_run(tab[v].base, tab[v].tog, tab[v].last_at, tab[v].cyc, tab[v].exp_err);

        sweep(0);
        sweep(1);

        @(posedge clk); #1;
        load_start = 1;
        scan_start = 1;
        @(posedge clk); #1;
        load_start = 0;
        scan_start = 0;
        chk("collision_enters_load", in_ready, 1);
        chk("collision_load_done_low", load_done, 0);
        chk("collision_no_read", int'(read1 | en), 0);
        @(posedge clk); #1;
        chk("collision_no_read_later", read1, 0);

        for (int b = 0; b < 40; b++) begin
            in_valid  = 1;
            in_weight = 9'(b);
            @(posedge clk); #1;
        end
        chk("pre_reset_write2", write2, 1);
        chk("pre_reset_address2", address2, 7);
        chk("pre_reset_weight2", weight2, 39);
        #2;
        rst = 0;
        #1;
        chk("async_reset_outputs", outs_or(), 0);
        in_valid = 0;
        @(posedge clk); #1;
        chk("reset_held_outputs", outs_or(), 0);
        rst = 1;
        load_run(-256, 0, 95, 96, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
